th_feed: RTL
============

Name: th_feed

Overview:
- Nibble-serial loader on the transmit side of the threshold filter's 4-bit load interface.
- Accepts full 8-bit samples through a valid/ready handshake, buffers them in a small FIFO, and accepts 8-bit threshold updates.
- Drives each word as two nibble writes: low nibble then high nibble, with the select lines `threshold`/`Higher` encoded for the filter.
- Sits between the sample source (ADC front end / test stimulus) and the filter input pins.

Parameters:
- DEPTH, 4, sample FIFO depth in entries; power of two, minimum 2.
- CNTW, 8, width of the sent-word counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  sample offered.
- s_data  input  8  sample value.
- s_ready  output  1  FIFO can accept; a sample transfers on a rising edge with s_valid & s_ready.
- th_wr  input  1  single-cycle strobe: new threshold on th_val.
- th_val  input  8  threshold value.
- nib  output  4  nibble to filter `in`.
- sel_th  output  1  to filter `threshold`; 1 = threshold write, 0 = sample write.
- sel_hi  output  1  to filter `Higher`; 1 = high nibble, 0 = low nibble.
- busy  output  1  FSM not IDLE, or FIFO non-empty, or threshold pending.
- sent_cnt  output  CNTW  count of complete sample words sent; wraps.

Behaviour:
- Reset (async, rst=1):
  - nib=0, sel_th=0, sel_hi=0, sent_cnt=0.
  - FIFO emptied, th_pend=0, FSM=IDLE.
  - While in reset, s_ready=0.
  - Reset mid-word abandons that word; no partial-word completion.
- All of nib, sel_th and sel_hi are registered and change only on rising clk edges.
- FSM states: IDLE, LO, HI.
  - Decision point is any edge where the FSM is in IDLE or HI.
  - If th_pend=1: go to LO with th_buf selected (sel_th=1, sel_hi=0, nib=th_buf[3:0]); th_pend clears.
  - Else if FIFO non-empty: pop the head into word_reg and go to LO (sel_th=0, sel_hi=0, nib=word[3:0]).
  - Else: go to IDLE.
  - LO always goes to HI: sel_hi=1, nib=word[7:4], sel_th unchanged.
  - When HI completes a sample word (sel_th=0), sent_cnt increments.
- Throughput: one word per 2 cycles, back-to-back with no gap (HI -> LO directly).
- IDLE outputs: hold the last HI-phase values (sel_hi=1, last high nibble, last sel_th). This re-writes an unchanged nibble in the filter and is harmless. The one exception is right after reset, when the outputs are all 0.
- Latency: a sample accepted at edge k into an empty FIFO with FSM in IDLE shows its LO nibble after edge k+1 and its HI nibble after edge k+2.
- Threshold has priority over queued samples, but only at word boundaries; a word in progress is never interrupted.
- th_wr while th_pend=1: th_buf is overwritten, and only the latest value is sent.
- th_wr on the same edge that consumes th_pend:
  - the old th_buf value is sent;
  - the new value is latched;
  - th_pend stays 1, so the new value is sent at the next decision point.
- FIFO:
  - s_ready = (count < DEPTH), combinational from count only.
  - Push and pop on the same edge are allowed and leave count unchanged.
  - No push when full, no pop when empty.
  - Pointers wrap modulo DEPTH.
- sent_cnt wraps from 2^CNTW-1 to 0.

Optional Feature:
- Macro: TH_FEED_DROP_LOW_EN.
- Defined:
  - A shadow register th_cur captures each threshold value at the moment its LO phase is issued; th_cur resets to 0.
  - A popped sample with value <= th_cur is discarded: no nibble writes, no sent_cnt increment, and the FSM re-evaluates at the next edge.
  - An 8-bit output drop_cnt (reset 0, wraps) counts discarded samples.
- Undefined: every sample is sent, and the drop_cnt port and th_cur register are absent.

Test Plan:
- Reset, then push 0xA5 into an idle block -> after edge k+1: nib=5, sel_th=0, sel_hi=0; after edge k+2: nib=A, sel_hi=1; sent_cnt=1; busy drops the cycle after.
- th_wr with 0x3C while sample 0x77 is in its LO phase -> 0x77 HI completes first, then threshold LO {sel_th=1, sel_hi=0, nib=C}, then HI {nib=3}.
- Hold s_valid=1 continuously with 6 words when DEPTH=4 -> s_ready falls when 4 are queued; words emerge back-to-back 2 cycles each, in order; sent_cnt=6.
- th_wr 0x10 then 0x20 on consecutive cycles while busy -> only 0x20 is transmitted. A th_wr issued on the consume edge produces two threshold words.
- Assert rst during a HI phase with 3 words queued -> all outputs 0 immediately; FIFO empty; busy=0 after release; no stale words are sent.
- With TH_FEED_DROP_LOW_EN defined: threshold 0x50, then samples 0x50, 0x51, 0x20 -> only 0x51 is transmitted; drop_cnt=2; sent_cnt=1.

Source files
------------

// File: rtl/th_feed.sv
// th_feed: nibble-serial loader that feeds queued samples and threshold updates to the filter's 4-bit load port.
// Optional macro TH_FEED_DROP_LOW_EN discards samples at or below the most recently sent threshold.
module th_feed #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    input  logic            th_wr,
    input  logic [7:0]      th_val,
    output logic [3:0]      nib,
    output logic            sel_th,
    output logic            sel_hi,
    output logic            busy,
`ifdef TH_FEED_DROP_LOW_EN
    output logic [7:0]      drop_cnt,
`endif
    output logic [CNTW-1:0] sent_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t          state_q, state_d;
    logic [3:0]      nib_q, nib_d;
    logic            sel_th_q, sel_th_d;
    logic            sel_hi_q, sel_hi_d;
    logic [CNTW-1:0] sent_cnt_q, sent_cnt_d;
    logic [7:0]      word_q, word_d;
    logic [7:0]      th_buf_q, th_buf_d;
    logic            th_pend_q, th_pend_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem [DEPTH];
    logic [7:0]      head;
    logic            push;
    logic            pop;
    logic            drop_head;
`ifdef TH_FEED_DROP_LOW_EN
    logic [7:0]      th_cur_q, th_cur_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
`endif

    assign s_ready  = ~rst & (count_q < CW'(DEPTH));
    assign push     = s_valid & s_ready;
    assign head     = mem[rd_ptr_q];
    assign nib      = nib_q;
    assign sel_th   = sel_th_q;
    assign sel_hi   = sel_hi_q;
    assign sent_cnt = sent_cnt_q;
    assign busy     = (state_q != IDLE) | (count_q != '0) | th_pend_q;

`ifdef TH_FEED_DROP_LOW_EN
    assign drop_head = (head <= th_cur_q);
    assign drop_cnt  = drop_cnt_q;
`else
    assign drop_head = 1'b0;
`endif

    // IDLE and HI are both word boundaries; a pending threshold wins over queued samples there.
    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        sel_th_d   = sel_th_q;
        sel_hi_d   = sel_hi_q;
        sent_cnt_d = sent_cnt_q;
        word_d     = word_q;
        th_buf_d   = th_buf_q;
        th_pend_d  = th_pend_q;
        pop        = 1'b0;
`ifdef TH_FEED_DROP_LOW_EN
        th_cur_d   = th_cur_q;
        drop_cnt_d = drop_cnt_q;
`endif
        case (state_q)
            LO: begin
                state_d  = HI;
                sel_hi_d = 1'b1;
                nib_d    = word_q[7:4];
                if (!sel_th_q) begin
                    sent_cnt_d = sent_cnt_q + 1'b1;
                end
            end
            default: begin
                if (th_pend_q) begin
                    state_d   = LO;
                    word_d    = th_buf_q;
                    nib_d     = th_buf_q[3:0];
                    sel_th_d  = 1'b1;
                    sel_hi_d  = 1'b0;
                    th_pend_d = 1'b0;
`ifdef TH_FEED_DROP_LOW_EN
                    th_cur_d  = th_buf_q;
`endif
                end else if (count_q != '0) begin
                    pop = 1'b1;
                    if (drop_head) begin
                        state_d = IDLE;
`ifdef TH_FEED_DROP_LOW_EN
                        drop_cnt_d = drop_cnt_q + 1'b1;
`endif
                    end else begin
                        state_d  = LO;
                        word_d   = head;
                        nib_d    = head[3:0];
                        sel_th_d = 1'b0;
                        sel_hi_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        // A strobe on the consuming edge re-arms the pending flag with the new value.
        if (th_wr) begin
            th_buf_d  = th_val;
            th_pend_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            nib_q      <= '0;
            sel_th_q   <= 1'b0;
            sel_hi_q   <= 1'b0;
            sent_cnt_q <= '0;
            word_q     <= '0;
            th_buf_q   <= '0;
            th_pend_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef TH_FEED_DROP_LOW_EN
            th_cur_q   <= '0;
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            nib_q      <= nib_d;
            sel_th_q   <= sel_th_d;
            sel_hi_q   <= sel_hi_d;
            sent_cnt_q <= sent_cnt_d;
            word_q     <= word_d;
            th_buf_q   <= th_buf_d;
            th_pend_q  <= th_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef TH_FEED_DROP_LOW_EN
            th_cur_q   <= th_cur_d;
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

endmodule
